// File: rtl/cordic_polar2rect.sv
// Iterative rotation-mode CORDIC: polar (magnitude, phase) to rectangular (x, y).
// One micro-rotation per clock; start/busy/done handshake; outputs hold until the next result.
module cordic_polar2rect #(
  parameter int INPUT_WIDTH = 16,
  parameter int INT_WIDTH   = 32,
  parameter int ITERATIONS  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic signed [INPUT_WIDTH-1:0] mag_in,
  input  logic signed [INT_WIDTH-1:0]   phase_in,
  output logic                        busy,
  output logic                        done,
  output logic signed [INT_WIDTH-1:0]   x_out,
  output logic signed [INT_WIDTH-1:0]   y_out
);

  localparam int IW = INT_WIDTH;
  localparam int PW = 2 * INPUT_WIDTH;
  localparam logic signed [IW-1:0] HALF_PI = IW'(421657428);
  localparam logic signed [IW-1:0] RND     = IW'(128);
  localparam logic signed [PW-1:0] INV_K   = PW'(19898);
  localparam logic [4:0]           LAST    = 5'(ITERATIONS - 1);

  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

  function automatic logic signed [IW-1:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:    atan_lut = IW'(210828714);
      5'd1:    atan_lut = IW'(124459457);
      5'd2:    atan_lut = IW'(65760959);
      5'd3:    atan_lut = IW'(33381290);
      5'd4:    atan_lut = IW'(16755422);
      5'd5:    atan_lut = IW'(8385879);
      5'd6:    atan_lut = IW'(4193963);
      5'd7:    atan_lut = IW'(2097109);
      5'd8:    atan_lut = IW'(1048571);
      5'd9:    atan_lut = IW'(524287);
      5'd10:   atan_lut = IW'(262144);
      5'd11:   atan_lut = IW'(131072);
      5'd12:   atan_lut = IW'(65536);
      5'd13:   atan_lut = IW'(32768);
      5'd14:   atan_lut = IW'(16384);
      5'd15:   atan_lut = IW'(8192);
      default: atan_lut = '0;
    endcase
  endfunction

  state_t                 state_q, state_d;
  logic signed [IW-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [IW-1:0]   xo_q, xo_d, yo_q, yo_d;
  logic [4:0]             iter_q, iter_d;
  logic                   busy_q, busy_d, done_q, done_d;

  // Magnitude pre-divided by the CORDIC gain, with 8 fractional guard bits.
  logic signed [PW-1:0]   mag_ext, prod, prod_sh;
  logic signed [IW-1:0]   mag_sc, x_sh, y_sh;

  assign mag_ext = PW'(mag_in);
  assign prod    = mag_ext * INV_K;
  assign prod_sh = prod >>> 7;
  assign mag_sc  = IW'(prod_sh);
  assign x_sh    = x_q >>> iter_q;
  assign y_sh    = y_q >>> iter_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = mag_sc;
          y_d     = '0;
          z_d     = phase_in;
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = ROT;
          // Fold outer quadrants by +-pi/2 so the residual stays in CORDIC range.
          if (phase_in > HALF_PI) begin
            x_d = '0;
            y_d = mag_sc;
            z_d = phase_in - HALF_PI;
          end else if (phase_in < -HALF_PI) begin
            x_d = '0;
            y_d = -mag_sc;
            z_d = phase_in + HALF_PI;
          end
        end
      end
      ROT: begin
        if (!z_q[IW-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_lut(iter_q);
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_lut(iter_q);
        end
        iter_d = iter_q + 5'd1;
        if (iter_q == LAST) state_d = DONE;
      end
      DONE: begin
        xo_d    = (x_q + RND) >>> 8;
        yo_d    = (y_q + RND) >>> 8;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign x_out = xo_q;
  assign y_out = yo_q;

endmodule

// File: tb/tb_cordic_polar2rect.sv
// Directed self-checking bench for cordic_polar2rect: accuracy vectors, latency,
// start-while-busy, input capture, mid-conversion reset and output hold.
module tb_cordic_polar2rect;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic signed [15:0] mag_in = '0;
  logic signed [31:0] phase_in = '0;
  logic               busy, done;
  logic signed [31:0] x_out, y_out;

  int checks = 0;
  int errors = 0;

  localparam int P4  = 210828714;
  localparam int P34 = 632486143;
  localparam int P2  = 421657428;
  localparam int PI  = 843314857;

  cordic_polar2rect dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mag_in(mag_in), .phase_in(phase_in),
    .busy(busy), .done(done), .x_out(x_out), .y_out(y_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint act, input longint exp, input int tol);
    checks++;
    assert ((act >= exp - tol) && (act <= exp + tol))
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, act, exp, tol);
    end
  endtask

  // Leaves the bench 1 time unit after the start-sampling edge.
  task automatic kick(input logic signed [15:0] m, input logic signed [31:0] p);
    @(negedge clk);
    mag_in = m; phase_in = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic conv(input string tag, input logic signed [15:0] m, input logic signed [31:0] p,
                      input int ex, input int ey, input int tol);
    int c;
    kick(m, p);
    wait_done(c);
    chk({tag, "_lat"}, c, 17, 0);
    chk({tag, "_x"}, x_out, ex, tol);
    chk({tag, "_y"}, y_out, ey, tol);
  endtask

  initial begin
    int c, ndone;
    logic signed [31:0] xh;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0, 0);
    chk("rst_done", done, 0, 0);
    chk("rst_x", x_out, 0, 0);
    chk("rst_y", y_out, 0, 0);
    @(negedge clk); rst_n = 1'b1;

    // Four diagonals
    conv("q1", 16'sd1414, P4, 1000, 1000, 2);
    conv("q2", 16'sd1414, P34, -1000, 1000, 2);
    conv("q3", 16'sd1414, -P34, -1000, -1000, 2);
    conv("q4", 16'sd1414, -P4, 1000, -1000, 2);

    // Axes and pre-rotation boundary
    conv("ph0", 16'sd1000, 0, 1000, 0, 2);
    conv("php2", 16'sd1000, P2, 0, 1000, 2);
    conv("phm2", 16'sd1000, -P2, 0, -1000, 2);
    conv("phpi", 16'sd1000, PI, -1000, 0, 2);
    conv("phm2p", 16'sd1000, -P2 - 1, 0, -1000, 2);

    // Edge magnitudes
    conv("mag0", 16'sd0, 123456789, 0, 0, 0);
    conv("magmax", 16'sd32767, 0, 32767, 0, 2);
    conv("magneg", -16'sd1000, P4, -707, -707, 2);

    // Round-trip vectors from magphase-format (1414, +-pi/4, +-3pi/4), recovered within 3
    conv("rt_pp", 16'sd1414, P4, 1000, 1000, 3);
    conv("rt_mn", 16'sd1414, -P34, -1000, -1000, 3);

    // Latency, ignored start while busy, input capture
    kick(16'sd1414, P4);
    mag_in = 16'sd7; phase_in = 0;
    ndone = 0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      if (k == 4) start = 1'b1;
      if (k == 5) start = 1'b0;
      if (k == 1) chk("hs_busy1", busy, 1, 0);
      if (k == 16) chk("hs_busy16", busy, 1, 0);
      if (k == 17) begin
        chk("hs_done17", done, 1, 0);
        chk("hs_busy17", busy, 0, 0);
      end
      if (k != 17 && done) ndone++;
    end
    chk("hs_extra_done", ndone, 0, 0);
    chk("cap_x", x_out, 1000, 2);
    chk("cap_y", y_out, 1000, 2);
    xh = x_out;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_x", x_out, xh, 0);

    // Reset mid-conversion
    kick(16'sd1000, 0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_busy", busy, 0, 0);
    chk("mrst_done", done, 0, 0);
    chk("mrst_x", x_out, 0, 0);
    chk("mrst_y", y_out, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("mrst_nodone", ndone, 0, 0);
    conv("post_rst", 16'sd1000, -P2, 0, -1000, 2);

    // A start right after done must wait one cycle in IDLE, then convert normally.
    kick(16'sd500, 0);
    wait_done(c);
    kick(16'sd500, P2);
    wait_done(c);
    chk("b2b_lat", c, 17, 0);
    chk("b2b_y", y_out, 500, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
